// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - VGA receive-side checker: sync timing, line count and lit pixels per frame
module vga_frame_monitor #(
   parameter int   CLKS_PER_PIX = 4,
   parameter int   H_ACTIVE     = 640,
   parameter int   H_BP         = 48,
   parameter int   H_SYNC       = 96,
   parameter int   H_TOTAL      = 800,
   parameter int   V_ACTIVE     = 480,
   parameter int   V_BP         = 33,
   parameter int   V_SYNC       = 2,
   parameter int   V_TOTAL      = 525,
   parameter logic SYNC_POL     = 1'b0,
   parameter int   HCNT_W       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  vgaRed,
   input  logic [5:0]  vgaGreen,
   input  logic [4:0]  vgaBlue,
   input  logic        hsync,
   input  logic        vsync,
   output logic        frame_done,
   output logic [18:0] lit_count,
   output logic [9:0]  line_count,
   output logic        hsync_err,
   output logic        vsync_err,
   output logic        locked
);

   typedef enum logic [1:0] {WAIT_VS = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

   localparam int PIX_SH = $clog2(CLKS_PER_PIX);
   localparam logic [HCNT_W-1:0] H_PERIOD    = HCNT_W'(H_TOTAL * CLKS_PER_PIX);
   localparam logic [HCNT_W-1:0] H_SYNC_CLKS = HCNT_W'(H_SYNC * CLKS_PER_PIX);
   localparam logic [HCNT_W-1:0] H_START     = HCNT_W'((H_SYNC + H_BP) * CLKS_PER_PIX);
   localparam logic [HCNT_W-1:0] H_ACT_CLKS  = HCNT_W'(H_ACTIVE * CLKS_PER_PIX);
   localparam logic [HCNT_W-1:0] HCNT_MAX    = '1;
   localparam logic [PIX_SH-1:0] PIX_HALF    = PIX_SH'(CLKS_PER_PIX / 2);
   localparam logic [9:0]        V_SYNC_L    = 10'(V_SYNC);
   localparam logic [9:0]        V_START     = 10'(V_SYNC + V_BP);
   localparam logic [9:0]        V_END       = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [9:0]        V_TOTAL_L   = 10'(V_TOTAL);

   state_t             state_q, state_d;
   logic               hs_q, hs_d, vs_q, vs_d;
   logic               hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
   logic [15:0]        rgb_q, rgb_d;
   logic               lit_q, lit_d;
   logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
   logic [9:0]         vcnt_q, vcnt_d;
   logic               first_hs_q, first_hs_d;
   logic [9:0]         lines_q, lines_d;
   logic [18:0]        lit_run_q, lit_run_d;
   logic               herr_q, herr_d, verr_q, verr_d;
   logic               frame_done_q, frame_done_d;
   logic [18:0]        lit_count_q, lit_count_d;
   logic [9:0]         line_count_q, line_count_d;
   logic               hsync_err_q, hsync_err_d;
   logic               vsync_err_q, vsync_err_d;

   logic               hs_assert, hs_deassert, vs_assert, vs_deassert;
   logic               measuring, h_err_now, v_err_now, sample;
   logic [HCNT_W-1:0]  h_rel;
   logic [9:0]         lines_inc;
   logic [18:0]        lit_run_inc;
   logic               h_frame_err, v_frame_err;

   assign hs_assert   = (hs_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
   assign hs_deassert = (hs_q != SYNC_POL) && (hs_prev_q == SYNC_POL);
   assign vs_assert   = (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);
   assign vs_deassert = (vs_q != SYNC_POL) && (vs_prev_q == SYNC_POL);
   assign measuring   = (state_q != WAIT_VS);

   // lit_q lags rgb_q one clock so it lines up with hcnt_q pixel positions
   assign h_rel  = hcnt_q - H_START;
   assign sample = measuring && lit_q && (hcnt_q >= H_START) && (h_rel < H_ACT_CLKS)
                   && (h_rel[PIX_SH-1:0] == PIX_HALF)
                   && (vcnt_q >= V_START) && (vcnt_q < V_END);

   assign h_err_now = measuring &&
                      ((hs_assert && !first_hs_q && ((hcnt_q + 1'b1) != H_PERIOD)) ||
                       (hs_deassert && (hcnt_d != H_SYNC_CLKS)));
   assign v_err_now = measuring && vs_deassert && (vcnt_d != V_SYNC_L);

   assign lines_inc   = (hs_assert && lines_q != 10'h3ff) ? lines_q + 10'd1 : lines_q;
   assign lit_run_inc = lit_run_q + {18'd0, sample};
   assign h_frame_err = herr_q | h_err_now;
   assign v_frame_err = verr_q | v_err_now | (lines_inc != V_TOTAL_L);

   always_comb begin
      hs_d      = hsync;
      vs_d      = vsync;
      hs_prev_d = hs_q;
      vs_prev_d = vs_q;
      rgb_d     = {vgaRed, vgaGreen, vgaBlue};
      lit_d     = |rgb_q;

      if (hs_assert)
         hcnt_d = '0;
      else if (hcnt_q == HCNT_MAX)
         hcnt_d = hcnt_q;
      else
         hcnt_d = hcnt_q + 1'b1;

      if (vs_assert)
         vcnt_d = '0;
      else if (hs_assert && vcnt_q != 10'h3ff)
         vcnt_d = vcnt_q + 10'd1;
      else
         vcnt_d = vcnt_q;

      state_d      = state_q;
      first_hs_d   = hs_assert ? 1'b0 : first_hs_q;
      lines_d      = lines_inc;
      lit_run_d    = lit_run_inc;
      herr_d       = h_frame_err;
      verr_d       = verr_q | v_err_now;
      frame_done_d = 1'b0;
      lit_count_d  = lit_count_q;
      line_count_d = line_count_q;
      hsync_err_d  = hsync_err_q;
      vsync_err_d  = vsync_err_q;

      case (state_q)
         WAIT_VS: begin
            if (vs_assert) begin
               state_d    = MEASURE;
               first_hs_d = 1'b1;
               lines_d    = '0;
               lit_run_d  = '0;
               herr_d     = 1'b0;
               verr_d     = 1'b0;
            end
         end
         default: begin
            // hsync has gone missing long enough to saturate hcnt
            if (hcnt_q == HCNT_MAX) begin
               state_d     = WAIT_VS;
               hsync_err_d = 1'b1;
            end else if (vs_assert) begin
               frame_done_d = 1'b1;
               lit_count_d  = lit_run_inc;
               line_count_d = lines_inc;
               hsync_err_d  = h_frame_err;
               vsync_err_d  = v_frame_err;
               state_d      = (h_frame_err || v_frame_err) ? MEASURE : LOCKED;
               lines_d      = '0;
               lit_run_d    = '0;
               herr_d       = 1'b0;
               verr_d       = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= WAIT_VS;
         hs_q         <= ~SYNC_POL;
         vs_q         <= ~SYNC_POL;
         hs_prev_q    <= ~SYNC_POL;
         vs_prev_q    <= ~SYNC_POL;
         rgb_q        <= '0;
         lit_q        <= 1'b0;
         hcnt_q       <= '0;
         vcnt_q       <= '0;
         first_hs_q   <= 1'b0;
         lines_q      <= '0;
         lit_run_q    <= '0;
         herr_q       <= 1'b0;
         verr_q       <= 1'b0;
         frame_done_q <= 1'b0;
         lit_count_q  <= '0;
         line_count_q <= '0;
         hsync_err_q  <= 1'b0;
         vsync_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         hs_prev_q    <= hs_prev_d;
         vs_prev_q    <= vs_prev_d;
         rgb_q        <= rgb_d;
         lit_q        <= lit_d;
         hcnt_q       <= hcnt_d;
         vcnt_q       <= vcnt_d;
         first_hs_q   <= first_hs_d;
         lines_q      <= lines_d;
         lit_run_q    <= lit_run_d;
         herr_q       <= herr_d;
         verr_q       <= verr_d;
         frame_done_q <= frame_done_d;
         lit_count_q  <= lit_count_d;
         line_count_q <= line_count_d;
         hsync_err_q  <= hsync_err_d;
         vsync_err_q  <= vsync_err_d;
      end
   end

   assign frame_done = frame_done_q;
   assign lit_count  = lit_count_q;
   assign line_count = line_count_q;
   assign hsync_err  = hsync_err_q;
   assign vsync_err  = vsync_err_q;
   assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - directed bench for vga_frame_monitor on a scaled-down timing
module tb_vga_frame_monitor;

   localparam int CPP = 2;
   localparam int HA  = 8;
   localparam int HB  = 2;
   localparam int HS  = 2;
   localparam int HT  = 16;
   localparam int VA  = 6;
   localparam int VB  = 2;
   localparam int VS  = 2;
   localparam int VT  = 12;

   logic        clk, rst;
   logic [4:0]  vgaRed;
   logic [5:0]  vgaGreen;
   logic [4:0]  vgaBlue;
   logic        hsync, vsync;
   logic        frame_done;
   logic [18:0] lit_count;
   logic [9:0]  line_count;
   logic        hsync_err, vsync_err, locked;

   int n_tests = 0;
   int n_fail  = 0;
   int fd_cnt  = 0;
   int fd_base;

   vga_frame_monitor #(
      .CLKS_PER_PIX(CPP), .H_ACTIVE(HA), .H_BP(HB), .H_SYNC(HS), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_BP(VB), .V_SYNC(VS), .V_TOTAL(VT), .SYNC_POL(1'b0), .HCNT_W(10)
   ) dut (
      .clk(clk), .rst(rst),
      .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
      .hsync(hsync), .vsync(vsync),
      .frame_done(frame_done), .lit_count(lit_count), .line_count(line_count),
      .hsync_err(hsync_err), .vsync_err(vsync_err), .locked(locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      hsync = 1'b1; vsync = 1'b1;
      vgaRed = '0; vgaGreen = '0; vgaBlue = '0;
      repeat (n) @(negedge clk);
   endtask

   // mode 1: pixel (0,0) plus the last active row; mode 2: one pixel in the front porch
   task automatic run_frame(input int nlines, input int vs_lines, input int mode, input int long_line);
      for (int l = 0; l < nlines; l++) begin
         int len;
         len = HT * CPP + ((l == long_line) ? 4 : 0);
         for (int c = 0; c < len; c++) begin
            int px, row;
            px  = c / CPP - (HS + HB);
            row = l - (VS + VB);
            hsync = (c < HS * CPP) ? 1'b0 : 1'b1;
            vsync = (l < vs_lines) ? 1'b0 : 1'b1;
            vgaRed = '0; vgaGreen = '0; vgaBlue = '0;
            if (mode == 1 && px >= 0 && px < HA && row >= 0 && row < VA) begin
               if (px == 0 && row == 0) vgaBlue = 5'h01;
               if (row == VA - 1) vgaGreen = 6'h20;
            end
            if (mode == 2 && px == HA + 1 && row == 0) vgaRed = 5'h10;
            @(negedge clk);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      idle(3);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_lit_count", lit_count, 0);
      chk("rst_line_count", line_count, 0);
      chk("rst_hsync_err", hsync_err, 0);
      chk("rst_vsync_err", vsync_err, 0);
      chk("rst_locked", locked, 0);
      rst = 1'b0;
      idle(4);

      run_frame(VT, VS, 0, -1);
      chk("no_fd_first_vsync", fd_cnt, 0);
      run_frame(VT, VS, 0, -1);
      chk("fd_count_1", fd_cnt, 1);
      chk("nom1_line_count", line_count, VT);
      chk("nom1_lit_count", lit_count, 0);
      chk("nom1_hsync_err", hsync_err, 0);
      chk("nom1_vsync_err", vsync_err, 0);
      run_frame(VT, VS, 0, -1);
      chk("fd_count_2", fd_cnt, 2);
      chk("nom2_line_count", line_count, VT);
      chk("nom2_lit_count", lit_count, 0);
      chk("nom2_errs", {hsync_err, vsync_err}, 0);
      chk("nom2_locked", locked, 1);

      run_frame(VT, VS, 1, -1);
      run_frame(VT, VS, 2, -1);
      chk("lit_pattern_count", lit_count, HA + 1);
      chk("lit_pattern_lines", line_count, VT);
      chk("lit_pattern_locked", locked, 1);
      run_frame(VT, VS, 0, -1);
      chk("lit_blanking_count", lit_count, 0);

      run_frame(VT, VS, 0, 5);
      run_frame(VT, VS, 0, -1);
      chk("hper_hsync_err", hsync_err, 1);
      chk("hper_vsync_err", vsync_err, 0);
      chk("hper_locked", locked, 0);
      chk("hper_line_count", line_count, VT);
      run_frame(VT, VS, 0, -1);
      chk("hper_recover_err", hsync_err, 0);
      chk("hper_recover_locked", locked, 1);

      run_frame(VT - 1, VS + 1, 0, -1);
      run_frame(VT, VS, 0, -1);
      chk("vert_vsync_err", vsync_err, 1);
      chk("vert_line_count", line_count, VT - 1);
      chk("vert_locked", locked, 0);
      chk("vert_hsync_err", hsync_err, 0);

      run_frame(7, VS, 0, -1);
      chk("pre_rst_locked", locked, 1);
      chk("pre_rst_line_count", line_count, VT);
      fd_base = fd_cnt;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_line_count", line_count, 0);
      chk("midrst_locked", locked, 0);
      chk("midrst_vsync_err", vsync_err, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      run_frame(VT - 7, 0, 0, -1);
      chk("postrst_line_count", line_count, 0);
      chk("postrst_lit_count", lit_count, 0);
      chk("postrst_locked", locked, 0);
      run_frame(VT, VS, 0, -1);
      chk("postrst_no_fd", fd_cnt - fd_base, 0);
      run_frame(VT, VS, 0, -1);
      chk("postrst_fd", fd_cnt - fd_base, 1);
      chk("postrst_frame_lines", line_count, VT);
      chk("postrst_frame_errs", {hsync_err, vsync_err}, 0);
      chk("postrst_frame_locked", locked, 1);

      idle(1100);
      chk("loss_locked", locked, 0);
      chk("loss_hsync_err", hsync_err, 1);
      fd_base = fd_cnt;
      run_frame(VT, VS, 0, -1);
      chk("loss_err_held", hsync_err, 1);
      chk("loss_no_fd", fd_cnt - fd_base, 0);
      run_frame(VT, VS, 0, -1);
      chk("resume_locked", locked, 1);
      chk("resume_hsync_err", hsync_err, 0);
      chk("resume_line_count", line_count, VT);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
